pot_spi_arbiter: RTL and testbench

Shares one SPI write channel (SCLK + DIN) among several digital-potentiometer requesters (VDD, DVDD, AVDD and limit pots) that each own a private active-low SYNC line. Round-robin arbitration picks one pending word, serializes it MSB-first, and acknowledges the requester. Sits between the UART command decoder's register writers and the `sclk_power`/`din_power`/`sync_*` pins.

---
 rtl/upum_pkg.sv | 25 ++
 rtl/pot_spi_arbiter_if.sv | 22 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/pot_spi_arbiter.sv | 129 ++++++++++++
 tb/tb_pot_spi_arbiter.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/upum_pkg.sv
// Shared constants for the UART-side peripheral masters: FSM encoding, default
// SPI word geometry and a constant-friendly ceil(log2) helper.
package upum_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SETUP    = 3'd1,
      ST_SHIFT_LO = 3'd2,
      ST_SHIFT_HI = 3'd3,
      ST_GAP      = 3'd4
   } state_t;

   localparam int DEF_N_REQ   = 4;
   localparam int DEF_DATA_W  = 16;
   localparam int DEF_CLK_DIV = 2;

   // Never returns 0 so that a width derived from it is always legal.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/pot_spi_arbiter_if.sv
// Requester-side handshake plus SPI pin bundle of the pot arbiter.
// The slave modport is the arbiter; the master modport is the requester/pin side.
interface pot_spi_arbiter_if
   import upum_pkg::*;
#(
   parameter int N_REQ  = DEF_N_REQ,
   parameter int DATA_W = DEF_DATA_W
);
   logic [N_REQ-1:0]        req;
   logic [N_REQ*DATA_W-1:0] req_data;
   logic [N_REQ-1:0]        ack;
   logic                    busy;
   logic [clog2(N_REQ)-1:0] grant_id;
   logic                    sclk;
   logic                    mosi;
   logic [N_REQ-1:0]        sync_n;

   modport master (output req, req_data,
                   input  ack, busy, grant_id, sclk, mosi, sync_n);
   modport slave  (input  req, req_data,
                   output ack, busy, grant_id, sclk, mosi, sync_n);
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit searching from last+1 (mod N_REQ).
// No state; the previous winner is lowest priority, so a lone requester still wins.
module rr_arbiter
   import upum_pkg::*;
#(
   parameter  int N_REQ = DEF_N_REQ,
   localparam int IW    = clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    last,
   output logic             grant_vld,
   output logic [IW-1:0]    grant_idx
);

   logic [IW-1:0] cand;

   // Walk from the farthest candidate back to the nearest so the nearest wins.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = last;
      cand      = last;
      for (int k = N_REQ; k >= 1; k--) begin
         cand = IW'((int'(last) + k) % N_REQ);
         if (req[cand]) begin
            grant_vld = 1'b1;
            grant_idx = cand;
         end
      end
   end

endmodule

// File: rtl/pot_spi_arbiter.sv
// Round-robin SPI write master for N pots sharing SCLK/MOSI, one SYNC_n each; req->sync_n 1 cycle,
// frame CLK_DIV*(1+2*DATA_W) cycles + 2*CLK_DIV gap. Requesters hold req until the ack pulse.
module pot_spi_arbiter
   import upum_pkg::*;
#(
   parameter int N_REQ   = DEF_N_REQ,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int CLK_DIV = DEF_CLK_DIV
) (
   input  logic             clk_100,
   input  logic             n_rst,
   pot_spi_arbiter_if.slave bus
);

   localparam int IW = clog2(N_REQ);
   localparam int DW = clog2(2 * CLK_DIV + 1);
   localparam int BW = clog2(DATA_W);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0] GAP_LAST = DW'(2 * CLK_DIV - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

   state_t              state, next_state;
   logic [DW-1:0]       div_cnt;
   logic [BW-1:0]       bit_cnt;
   logic [DATA_W-1:0]   shreg;
   logic [DATA_W-1:0]   words [N_REQ];
   logic [DATA_W-1:0]   word;
   logic [IW-1:0]       last, gid, grant_idx;
   logic                grant_vld, phase_last;
   logic                sclk_q, sclk_d, mosi_q, mosi_d, busy_q, busy_d;
   logic [N_REQ-1:0]    sync_n_q, sync_n_d, ack_q, ack_d;

   rr_arbiter #(.N_REQ(N_REQ)) u_rr (
      .req       (bus.req),
      .last      (last),
      .grant_vld (grant_vld),
      .grant_idx (grant_idx)
   );

   always_comb begin
      for (int i = 0; i < N_REQ; i++) words[i] = bus.req_data[i*DATA_W +: DATA_W];
      word = words[grant_idx];
   end

   assign phase_last = (state == ST_GAP) ? (div_cnt == GAP_LAST) : (div_cnt == DIV_LAST);

   always_ff @(posedge clk_100 or negedge n_rst) begin
      if (!n_rst) begin
         state    <= ST_IDLE;
         div_cnt  <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         gid      <= '0;
         last     <= IW'(N_REQ - 1);
         sclk_q   <= 1'b1;
         mosi_q   <= 1'b0;
         sync_n_q <= '1;
         ack_q    <= '0;
         busy_q   <= 1'b0;
      end else begin
         state   <= next_state;
         div_cnt <= (next_state != state || state == ST_IDLE) ? '0 : div_cnt + DW'(1);
         if (state == ST_IDLE && grant_vld) begin
            gid     <= grant_idx;
            shreg   <= word;
            bit_cnt <= '0;
         end
         if (state == ST_SHIFT_LO && next_state == ST_SHIFT_HI) shreg <= {shreg[DATA_W-2:0], 1'b0};
         if (state == ST_SHIFT_HI && next_state == ST_SHIFT_LO) bit_cnt <= bit_cnt + BW'(1);
         if (state == ST_SHIFT_HI && next_state == ST_GAP) last <= gid;
         sclk_q   <= sclk_d;
         mosi_q   <= mosi_d;
         sync_n_q <= sync_n_d;
         ack_q    <= ack_d;
         busy_q   <= busy_d;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:     if (grant_vld)  next_state = ST_SETUP;
         ST_SETUP:    if (phase_last) next_state = ST_SHIFT_LO;
         ST_SHIFT_LO: if (phase_last) next_state = ST_SHIFT_HI;
         ST_SHIFT_HI: if (phase_last) next_state = (bit_cnt == BIT_LAST) ? ST_GAP : ST_SHIFT_LO;
         ST_GAP:      if (phase_last) next_state = ST_IDLE;
         default:     next_state = ST_IDLE;
      endcase
   end

   // Next values of the registered pins; busy lingers one cycle past GAP so it spans grant-to-grant.
   always_comb begin
      sclk_d   = sclk_q;
      mosi_d   = mosi_q;
      sync_n_d = sync_n_q;
      ack_d    = '0;
      busy_d   = (state != ST_IDLE) || (next_state != ST_IDLE);
      case (state)
         ST_IDLE: if (grant_vld) begin
            sync_n_d = ~(N_REQ'(1) << grant_idx);
            sclk_d   = 1'b1;
            mosi_d   = word[DATA_W-1];
         end
         ST_SETUP: if (phase_last) sclk_d = 1'b0;
         ST_SHIFT_LO: if (phase_last) begin
            sclk_d = 1'b1;
            mosi_d = shreg[DATA_W-2];
         end
         ST_SHIFT_HI: if (phase_last) begin
            if (bit_cnt == BIT_LAST) begin
               mosi_d   = 1'b0;
               sync_n_d = '1;
               ack_d    = N_REQ'(1) << gid;
            end else begin
               sclk_d = 1'b0;
            end
         end
         default: ;
      endcase
   end

   assign bus.sclk     = sclk_q;
   assign bus.mosi     = mosi_q;
   assign bus.sync_n   = sync_n_q;
   assign bus.ack      = ack_q;
   assign bus.busy     = busy_q;
   assign bus.grant_id = gid;

endmodule

// File: tb/tb_pot_spi_arbiter.sv
// Directed bench for pot_spi_arbiter: default instance (4 x 16 bit, CLK_DIV 2) and a
// wide instance (4 x 24 bit, CLK_DIV 1) sharing clock and reset.
module tb_pot_spi_arbiter;

   logic clk_100 = 1'b0;
   logic n_rst   = 1'b0;
   int   n_pass  = 0;
   int   n_total = 0;

   always #5 clk_100 = ~clk_100;

   pot_spi_arbiter_if #(.N_REQ(4), .DATA_W(16)) b0 ();
   pot_spi_arbiter_if #(.N_REQ(4), .DATA_W(24)) b1 ();

   pot_spi_arbiter #(.N_REQ(4), .DATA_W(16), .CLK_DIV(2)) u0 (
      .clk_100 (clk_100), .n_rst (n_rst), .bus (b0.slave));
   pot_spi_arbiter #(.N_REQ(4), .DATA_W(24), .CLK_DIV(1)) u1 (
      .clk_100 (clk_100), .n_rst (n_rst), .bus (b1.slave));

   task automatic do_reset();
      @(negedge clk_100);
      n_rst = 1'b0;
      b0.req = '0; b0.req_data = '0;
      b1.req = '0; b1.req_data = '0;
      repeat (3) @(negedge clk_100);
      n_rst = 1'b1;
      @(negedge clk_100);
   endtask

   // Observe one frame on u0 starting at a negedge; returns one cycle after sync_n rises.
   task automatic capture0(output int id, output logic [31:0] word, output int low_cyc,
                           output int falls, output int acks, output logic [3:0] ack_rise,
                           output bit overlap, output longint t_start, output int gid);
      int   t;
      logic prev_sclk;
      id = -1; word = '0; low_cyc = 0; falls = 0; acks = 0; ack_rise = '0;
      overlap = 1'b0; t_start = 0; gid = -1; t = 0;
      while ((&b0.sync_n) && t < 500) begin
         @(negedge clk_100);
         t++;
      end
      if (t >= 500) return;
      t_start = $time;
      gid = int'(b0.grant_id);
      for (int i = 0; i < 4; i++) if (!b0.sync_n[i]) id = i;
      prev_sclk = b0.sclk;
      while (!(&b0.sync_n) && low_cyc < 1000) begin
         low_cyc++;
         if ($countones(~b0.sync_n) > 1) overlap = 1'b1;
         if (b0.ack != 4'b0) acks++;
         if (prev_sclk && !b0.sclk) begin
            falls++;
            word = {word[30:0], b0.mosi};
         end
         prev_sclk = b0.sclk;
         @(negedge clk_100);
      end
      ack_rise = b0.ack;
      if (b0.ack != 4'b0) acks++;
      @(negedge clk_100);
      if (b0.ack != 4'b0) acks++;
   endtask

   task automatic test_reset();
      n_rst = 1'b0;
      b0.req = '0; b0.req_data = '0;
      b1.req = '0; b1.req_data = '0;
      repeat (2) @(negedge clk_100);
      n_total++;
      if ({b0.sclk, b0.mosi} !== 2'b10) $display("FAIL reset_sclk_mosi: got %b want 10", {b0.sclk, b0.mosi});
      else n_pass++;
      n_total++;
      if (b0.sync_n !== 4'hF) $display("FAIL reset_sync_n: got %h want f", b0.sync_n);
      else n_pass++;
      n_total++;
      if ({b0.ack, b0.busy, b0.grant_id} !== 7'd0) $display("FAIL reset_ack_busy_gid: got %b want 0", {b0.ack, b0.busy, b0.grant_id});
      else n_pass++;
      n_total++;
      if ({b1.sclk, b1.sync_n, b1.busy} !== 6'b111110) $display("FAIL reset_wide: got %b want 111110", {b1.sclk, b1.sync_n, b1.busy});
      else n_pass++;
      n_rst = 1'b1;
      @(negedge clk_100);
   endtask

   task automatic test_single();
      int id, low, falls, acks, gid; logic [31:0] w; logic [3:0] ar; bit ov; longint ts;
      b0.req_data[15:0] = 16'h1802;
      b0.req[0] = 1'b1;
      @(negedge clk_100);
      n_total++;
      if (b0.sync_n !== 4'b1110) $display("FAIL single_latency: sync_n got %b want 1110", b0.sync_n);
      else n_pass++;
      capture0(id, w, low, falls, acks, ar, ov, ts, gid);
      b0.req[0] = 1'b0;
      n_total++;
      if (w !== 32'h1802) $display("FAIL single_word: got %h want 1802", w);
      else n_pass++;
      n_total++;
      if (low !== 66) $display("FAIL single_sync_low: got %0d want 66", low);
      else n_pass++;
      n_total++;
      if (falls !== 16) $display("FAIL single_falls: got %0d want 16", falls);
      else n_pass++;
      n_total++;
      if (ar !== 4'b0001 || acks !== 1) $display("FAIL single_ack: rise %b count %0d want 0001 and 1", ar, acks);
      else n_pass++;
      repeat (8) @(negedge clk_100);
      n_total++;
      if (b0.busy !== 1'b0) $display("FAIL single_idle_busy: got %b want 0", b0.busy);
      else n_pass++;
   endtask

   task automatic test_all_four();
      int id, low, falls, acks, gid; logic [31:0] w; logic [3:0] ar; bit ov, any_ov; longint ts, tprev;
      do_reset();
      any_ov = 1'b0; tprev = 0;
      b0.req_data = {16'hA004, 16'hA003, 16'hA002, 16'hA001};
      b0.req = 4'hF;
      for (int k = 0; k < 4; k++) begin
         capture0(id, w, low, falls, acks, ar, ov, ts, gid);
         if (id >= 0) b0.req[id] = 1'b0;
         any_ov |= ov;
         n_total++;
         if (id !== k || gid !== k) $display("FAIL all4_order[%0d]: id %0d grant_id %0d want %0d", k, id, gid, k);
         else n_pass++;
         n_total++;
         if (w !== 32'hA001 + k || low !== 66) $display("FAIL all4_frame[%0d]: word %h low %0d want %h 66", k, w, low, 32'hA001 + k);
         else n_pass++;
         n_total++;
         if (acks !== 1 || ar !== (4'b1 << k)) $display("FAIL all4_ack[%0d]: count %0d rise %b", k, acks, ar);
         else n_pass++;
         if (k > 0) begin
            n_total++;
            if (ts - tprev !== 710) $display("FAIL all4_grant_gap[%0d]: got %0d want 710", k, ts - tprev);
            else n_pass++;
         end
         tprev = ts;
      end
      n_total++;
      if (any_ov !== 1'b0) $display("FAIL all4_overlap: two sync_n low seen");
      else n_pass++;
      repeat (8) @(negedge clk_100);
   endtask

   task automatic test_fairness();
      int id, low, falls, acks, gid; logic [31:0] w; logic [3:0] ar; bit ov; longint ts;
      int exp_id [4] = '{2, 3, 0, 2};
      logic [15:0] exp_w [4] = '{16'h2222, 16'h3333, 16'h0F0F, 16'h2222};
      do_reset();
      b0.req_data = {16'h3333, 16'h2222, 16'h1111, 16'h0F0F};
      b0.req = 4'b0010;
      capture0(id, w, low, falls, acks, ar, ov, ts, gid);
      b0.req[1] = 1'b0;
      n_total++;
      if (id !== 1 || w !== 32'h1111) $display("FAIL fair_prime: id %0d word %h want 1 1111", id, w);
      else n_pass++;
      b0.req = 4'b1101;
      for (int k = 0; k < 4; k++) begin
         capture0(id, w, low, falls, acks, ar, ov, ts, gid);
         if (id >= 0 && id != 2) b0.req[id] = 1'b0;
         n_total++;
         if (id !== exp_id[k] || w !== {16'h0, exp_w[k]}) $display("FAIL fair_order[%0d]: id %0d word %h want %0d %h", k, id, w, exp_id[k], exp_w[k]);
         else n_pass++;
      end
      b0.req[2] = 1'b0;
      repeat (8) @(negedge clk_100);
   endtask

   task automatic test_drop();
      int id, low, falls, acks, gid, stray; logic [31:0] w; logic [3:0] ar; bit ov; longint ts;
      b0.req_data[31:16] = 16'hC3A5;
      b0.req[1] = 1'b1;
      fork
         capture0(id, w, low, falls, acks, ar, ov, ts, gid);
         begin
            repeat (11) @(negedge clk_100);
            b0.req[1] = 1'b0;
            b0.req_data[31:16] = 16'h1234;
         end
      join
      n_total++;
      if (id !== 1 || w !== 32'hC3A5 || falls !== 16) $display("FAIL drop_word: id %0d word %h falls %0d want 1 c3a5 16", id, w, falls);
      else n_pass++;
      n_total++;
      if (ar !== 4'b0010 || acks !== 1) $display("FAIL drop_ack: rise %b count %0d want 0010 1", ar, acks);
      else n_pass++;
      stray = 0;
      repeat (100) begin
         @(negedge clk_100);
         if (b0.sync_n !== 4'hF) stray++;
      end
      n_total++;
      if (stray !== 0) $display("FAIL drop_no_refire: %0d cycles with sync low, want 0", stray);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      int id, low, falls, acks, gid, t, f, bad_ack; logic [31:0] w; logic [3:0] ar; bit ov; longint ts;
      logic prev;
      b0.req_data[63:48] = 16'hBEEF;
      b0.req[3] = 1'b1;
      t = 0; f = 0; prev = 1'b1;
      while (f < 7 && t < 400) begin
         @(negedge clk_100);
         t++;
         if (!b0.sync_n[3] && prev && !b0.sclk) f++;
         prev = b0.sclk;
      end
      n_total++;
      if (f !== 7) $display("FAIL rstmid_reach_bit7: falls %0d want 7", f);
      else n_pass++;
      #2 n_rst = 1'b0;
      #1;
      n_total++;
      if ({b0.sclk, b0.mosi, b0.sync_n, b0.ack, b0.busy} !== 11'b10_1111_0000_0) $display("FAIL rstmid_outputs: got %b want 10111100000", {b0.sclk, b0.mosi, b0.sync_n, b0.ack, b0.busy});
      else n_pass++;
      bad_ack = 0;
      repeat (3) begin
         @(negedge clk_100);
         if (b0.ack !== 4'b0) bad_ack++;
      end
      n_rst = 1'b1;
      capture0(id, w, low, falls, acks, ar, ov, ts, gid);
      b0.req[3] = 1'b0;
      n_total++;
      if (bad_ack !== 0) $display("FAIL rstmid_no_ack: %0d ack cycles want 0", bad_ack);
      else n_pass++;
      n_total++;
      if (id !== 3 || w !== 32'hBEEF || low !== 66 || falls !== 16 || ar !== 4'b1000) $display("FAIL rstmid_restart: id %0d word %h low %0d falls %0d ack %b", id, w, low, falls, ar);
      else n_pass++;
      repeat (8) @(negedge clk_100);
   endtask

   task automatic test_wide();
      int low, falls, busy_c, acks, t, bad_sync; logic [31:0] w; logic [3:0] ack_v; logic prev; bit seen;
      b1.req_data[23:0] = 24'hC35A5F;
      b1.req[0] = 1'b1;
      low = 0; falls = 0; busy_c = 0; acks = 0; t = 0; bad_sync = 0;
      w = '0; prev = 1'b1; seen = 1'b0; ack_v = '0;
      while (t < 300) begin
         @(negedge clk_100);
         t++;
         if (!b1.sync_n[0]) low++;
         if (b1.sync_n !== 4'hF && b1.sync_n !== 4'hE) bad_sync++;
         if (!b1.sync_n[0] && prev && !b1.sclk) begin
            falls++;
            w = {w[30:0], b1.mosi};
         end
         prev = b1.sclk;
         if (b1.ack != 4'b0) begin
            acks++;
            ack_v = b1.ack;
            b1.req[0] = 1'b0;
         end
         if (b1.busy) begin
            busy_c++;
            seen = 1'b1;
         end else if (seen) break;
      end
      n_total++;
      if (low !== 49) $display("FAIL wide_sync_low: got %0d want 49", low);
      else n_pass++;
      n_total++;
      if (falls !== 24 || w !== 32'hC35A5F) $display("FAIL wide_word: falls %0d word %h want 24 c35a5f", falls, w);
      else n_pass++;
      n_total++;
      if (busy_c !== 52) $display("FAIL wide_busy: got %0d want 52", busy_c);
      else n_pass++;
      n_total++;
      if (acks !== 1 || ack_v !== 4'b0001 || bad_sync !== 0) $display("FAIL wide_ack_sync: acks %0d ack %b badsync %0d", acks, ack_v, bad_sync);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_all_four();
      test_fairness();
      test_drop();
      test_reset_mid();
      test_wide();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
